// File: rtl/backend_stall_ctrl.sv
// backend_stall_ctrl: merges per-stage stall/clear requests for both backend pipes,
// arbitrates EX vs M2 redirects, and blocks issue for a post-flush window.
`default_nettype none

module backend_stall_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ex_stall_req_i,
  input  logic [1:0]       m1_stall_req_i,
  input  logic [1:0]       m2_stall_req_i,
  input  logic             ex_clr_req_i,
  input  logic [31:0]      ex_target_i,
  input  logic             m2_clr_req_i,
  input  logic             m2_clr_exclude_self_i,
  input  logic [31:0]      m2_target_i,
  output logic [2:0]       stall_vec_o,
  output logic [1:0][2:0]  clr_vec_o,
  output logic             issue_allow_o,
  output logic             frontend_flush_o,
  output logic [31:0]      frontend_target_o,
  output logic [31:0]      stall_cycles_o
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  stall;
  logic        ex_acc;
  logic        m2_acc;

  // A stalled older stage freezes every younger stage behind it.
  always_comb begin
    stall[2] = |m2_stall_req_i;
    stall[1] = stall[2] | (|m1_stall_req_i);
    stall[0] = stall[1] | (|ex_stall_req_i);
  end

  assign stall_vec_o = stall;
  assign ex_acc      = ex_clr_req_i & ~stall[0];
  assign m2_acc      = m2_clr_req_i & ~stall[2];

  always_comb begin
    clr_vec_o = '0;
    if (ex_acc) begin
      clr_vec_o[1][0] = 1'b1;
    end
    if (m2_acc) begin
      clr_vec_o[0][1:0] = 2'b11;
      clr_vec_o[0][2]   = ~m2_clr_exclude_self_i;
      clr_vec_o[1]      = 3'b111;
    end
  end

  assign issue_allow_o = ~rst & (state == RUN) & ~stall[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RUN;
      cnt               <= 4'd0;
      frontend_flush_o  <= 1'b0;
      frontend_target_o <= 32'd0;
      stall_cycles_o    <= 32'd0;
    end else begin
      frontend_flush_o <= 1'b0;
      if (stall[0]) begin
        stall_cycles_o <= stall_cycles_o + 32'd1;
      end
      case (state)
        RUN: begin
          if (ex_acc | m2_acc) begin
            frontend_target_o <= m2_acc ? m2_target_i : ex_target_i;
            frontend_flush_o  <= 1'b1;
            cnt               <= FLUSH_LOAD;
            state             <= FLUSH;
          end
        end
        FLUSH: begin
          // A branch here is younger than the flush already taken; only M2 can re-redirect.
          if (m2_acc) begin
            frontend_target_o <= m2_target_i;
            frontend_flush_o  <= 1'b1;
            cnt               <= FLUSH_LOAD;
          end else if (cnt <= 4'd1) begin
            cnt   <= 4'd0;
            state <= RUN;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_backend_stall_ctrl.sv
// Directed self-checking bench for backend_stall_ctrl (FLUSH_CYCLES = 2).
`default_nettype none

module tb_backend_stall_ctrl;

  logic             clk;
  logic             rst;
  logic [1:0]       ex_stall_req_i;
  logic [1:0]       m1_stall_req_i;
  logic [1:0]       m2_stall_req_i;
  logic             ex_clr_req_i;
  logic [31:0]      ex_target_i;
  logic             m2_clr_req_i;
  logic             m2_clr_exclude_self_i;
  logic [31:0]      m2_target_i;
  logic [2:0]       stall_vec_o;
  logic [1:0][2:0]  clr_vec_o;
  logic             issue_allow_o;
  logic             frontend_flush_o;
  logic [31:0]      frontend_target_o;
  logic [31:0]      stall_cycles_o;

  int errors = 0;
  int checks = 0;

  backend_stall_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ex_stall_req_i        (ex_stall_req_i),
    .m1_stall_req_i        (m1_stall_req_i),
    .m2_stall_req_i        (m2_stall_req_i),
    .ex_clr_req_i          (ex_clr_req_i),
    .ex_target_i           (ex_target_i),
    .m2_clr_req_i          (m2_clr_req_i),
    .m2_clr_exclude_self_i (m2_clr_exclude_self_i),
    .m2_target_i           (m2_target_i),
    .stall_vec_o           (stall_vec_o),
    .clr_vec_o             (clr_vec_o),
    .issue_allow_o         (issue_allow_o),
    .frontend_flush_o      (frontend_flush_o),
    .frontend_target_o     (frontend_target_o),
    .stall_cycles_o        (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_stall_req_i = 2'b00; m1_stall_req_i = 2'b00; m2_stall_req_i = 2'b00;
    ex_clr_req_i = 1'b0; ex_target_i = 32'd0;
    m2_clr_req_i = 1'b0; m2_clr_exclude_self_i = 1'b0; m2_target_i = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // Reset: combinational stall follows inputs, issue forced low, counter does not count.
    m1_stall_req_i = 2'b10;
    cyc(); #1;
    chk("rst_stall_vec", 32'(stall_vec_o), 32'h3);
    chk("rst_issue", 32'(issue_allow_o), 32'h0);
    cyc(); #1;
    chk("rst_flush", 32'(frontend_flush_o), 32'h0);
    chk("rst_target", frontend_target_o, 32'h0);
    chk("rst_stall_cnt", stall_cycles_o, 32'h0);

    rst = 1'b0; idle();
    cyc(); idle(); #1;
    chk("run_issue", 32'(issue_allow_o), 32'h1);
    chk("run_stall_cnt", stall_cycles_o, 32'h0);

    // Stall propagation: five cycles of pipe-1 M1 stall.
    for (int i = 0; i < 5; i++) begin
      cyc(); m1_stall_req_i = 2'b10; #1;
      if (i == 0) begin
        chk("m1_stall_vec", 32'(stall_vec_o), 32'h3);
        chk("m1_stall_issue", 32'(issue_allow_o), 32'h0);
      end
    end
    cyc(); idle(); #1;
    chk("stall_cnt_5", stall_cycles_o, 32'd5);
    chk("unstall_issue", 32'(issue_allow_o), 32'h1);
    cyc(); ex_stall_req_i = 2'b01; #1;
    chk("ex_stall_vec", 32'(stall_vec_o), 32'h1);
    cyc(); idle(); m2_stall_req_i = 2'b10; #1;
    chk("m2_stall_vec", 32'(stall_vec_o), 32'h7);
    cyc(); idle(); #1;
    chk("stall_cnt_7", stall_cycles_o, 32'd7);

    // Branch flush.
    ex_clr_req_i = 1'b1; ex_target_i = 32'h1C000100; #1;
    chk("br_clr_vec", 32'(clr_vec_o), 32'h08);
    chk("br_issue_T", 32'(issue_allow_o), 32'h1);
    cyc(); idle(); #1;
    chk("br_flush_T1", 32'(frontend_flush_o), 32'h1);
    chk("br_target_T1", frontend_target_o, 32'h1C000100);
    chk("br_issue_T1", 32'(issue_allow_o), 32'h0);
    cyc(); #1;
    chk("br_flush_T2", 32'(frontend_flush_o), 32'h0);
    chk("br_issue_T2", 32'(issue_allow_o), 32'h0);
    cyc(); #1;
    chk("br_issue_T3", 32'(issue_allow_o), 32'h1);

    // Gated clear: M2 stall blocks the branch redirect.
    cyc(); ex_clr_req_i = 1'b1; ex_target_i = 32'h1C000500; m2_stall_req_i = 2'b01; #1;
    chk("gate_clr_vec", 32'(clr_vec_o), 32'h0);
    chk("gate_stall_vec", 32'(stall_vec_o), 32'h7);
    cyc(); idle(); #1;
    chk("gate_no_flush", 32'(frontend_flush_o), 32'h0);
    chk("gate_issue", 32'(issue_allow_o), 32'h1);
    chk("stall_cnt_8", stall_cycles_o, 32'd8);

    // Syscall, then M2 override during FLUSH, then an ignored branch.
    m2_clr_req_i = 1'b1; m2_clr_exclude_self_i = 1'b1; m2_target_i = 32'h1C000008; #1;
    chk("sys_clr_vec", 32'(clr_vec_o), 32'h3B);
    cyc(); idle(); #1;
    chk("sys_flush", 32'(frontend_flush_o), 32'h1);
    chk("sys_target", frontend_target_o, 32'h1C000008);
    m2_clr_req_i = 1'b1; m2_clr_exclude_self_i = 1'b0; m2_target_i = 32'h1C000200; #1;
    chk("ovr_clr_vec", 32'(clr_vec_o), 32'h3F);
    cyc(); idle(); ex_clr_req_i = 1'b1; ex_target_i = 32'h1C000300; #1;
    chk("ovr_flush", 32'(frontend_flush_o), 32'h1);
    chk("ovr_target", frontend_target_o, 32'h1C000200);
    chk("ovr_issue", 32'(issue_allow_o), 32'h0);
    chk("ign_clr_vec", 32'(clr_vec_o), 32'h08);
    cyc(); idle(); #1;
    chk("ign_no_flush", 32'(frontend_flush_o), 32'h0);
    chk("ign_target", frontend_target_o, 32'h1C000200);
    chk("ovr_window", 32'(issue_allow_o), 32'h0);
    cyc(); #1;
    chk("ovr_window_end", 32'(issue_allow_o), 32'h1);

    // Same-cycle conflict: M2 wins, single pulse.
    ex_clr_req_i = 1'b1; ex_target_i = 32'h100;
    m2_clr_req_i = 1'b1; m2_clr_exclude_self_i = 1'b1; m2_target_i = 32'h200; #1;
    chk("conf_clr_vec", 32'(clr_vec_o), 32'h3B);
    cyc(); idle(); #1;
    chk("conf_flush", 32'(frontend_flush_o), 32'h1);
    chk("conf_target", frontend_target_o, 32'h200);
    cyc(); #1;
    chk("conf_single", 32'(frontend_flush_o), 32'h0);
    chk("conf_issue", 32'(issue_allow_o), 32'h0);
    cyc(); #1;
    chk("conf_issue_end", 32'(issue_allow_o), 32'h1);

    // Reset mid-FLUSH.
    ex_clr_req_i = 1'b1; ex_target_i = 32'h44;
    cyc(); idle(); #1;
    chk("rf_flush", 32'(frontend_flush_o), 32'h1);
    rst = 1'b1; #1;
    chk("rf_rst_issue", 32'(issue_allow_o), 32'h0);
    cyc(); rst = 1'b0; #1;
    chk("rf_no_flush", 32'(frontend_flush_o), 32'h0);
    chk("rf_target", frontend_target_o, 32'h0);
    chk("rf_issue", 32'(issue_allow_o), 32'h1);
    chk("rf_stall_cnt", stall_cycles_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/backend_stall_ctrl.md
# backend_stall_ctrl

Central stall, clear and redirect sequencer for the two lock-stepped backend pipes: pipe 0 is the main pipe with BPF, LSU and CSR; pipe 1 is the secondary ALU pipe. It merges per-stage stall and clear requests into common `stall_vec` / per-pipe `clr_vec` vectors. It arbitrates branch (EX) against exception/ertn (M2) redirects and holds issue off for a programmable post-flush window. It also keeps a stall-cycle performance counter.

## Interface
- `FLUSH_CYCLES`, default 2: cycles issue is blocked after an accepted redirect (legal range 1..15).
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `ex_stall_req_i`  in  2  per-pipe EX stall request, bit p = pipe p
- `m1_stall_req_i`  in  2  per-pipe M1 stall request
- `m2_stall_req_i`  in  2  per-pipe M2 stall request (LSU busy)
- `ex_clr_req_i`  in  1  pipe-0 branch mispredict flush
- `ex_target_i`  in  32  pipe-0 branch redirect PC
- `m2_clr_req_i`  in  1  pipe-0 CSR redirect (exception/ertn)
- `m2_clr_exclude_self_i`  in  1  the M2 instruction itself retires (syscall/ertn)
- `m2_target_i`  in  32  CSR redirect PC
- `stall_vec_o`  out  3  stage stall to both pipes: [0] EX, [1] M1, [2] M2
- `clr_vec_o`  out  2x3  per-pipe clear; [p][k] kills the instruction leaving stage k of pipe p
- `issue_allow_o`  out  1  issue stage may fire this cycle
- `frontend_flush_o`  out  1  one-cycle redirect pulse to the frontend
- `frontend_target_o`  out  32  redirect PC, valid while `frontend_flush_o`
- `stall_cycles_o`  out  32  count of cycles with `stall_vec_o[0]` = 1

## Operation
- Stall: `stall_vec_o[2]` = |`m2_stall_req_i`; `[1]` = `[2]` | (|`m1_stall_req_i`); `[0]` = `[1]` | (|`ex_stall_req_i`). The same vector goes to both pipes. Combinational.
- Age order: older stage beats younger stage. Within a stage, pipe 0 is older than pipe 1.
- EX clear is accepted only when `ex_clr_req_i` & ~`stall_vec_o[0]` (ex_acc). It kills pipe-1 EX only: `clr_vec_o[1][0]` = 1. The branch itself continues.
- M2 clear is accepted only when `m2_clr_req_i` & ~`stall_vec_o[2]` (m2_acc). It kills:
  - `clr_vec_o[0][1:0]` and `clr_vec_o[1][2:0]`;
  - `clr_vec_o[0][2]` = ~`m2_clr_exclude_self_i`.
- Simultaneous ex_acc and m2_acc: M2 wins. The target is `m2_target_i`. Clear bits are the OR of both.
- FSM states:
  - RUN: `issue_allow_o` = ~`stall_vec_o[0]`. On ex_acc|m2_acc, latch the target (M2 priority), load cnt = `FLUSH_CYCLES`, go FLUSH.
  - FLUSH: `issue_allow_o` = 0 and cnt decrements each cycle. When cnt reaches 1 (i.e. the next value would be 0), return to RUN.
  - An m2_acc while in FLUSH overrides the latched target, reloads cnt and re-pulses `frontend_flush_o`.
  - An ex_acc while in FLUSH is ignored, because the branch is younger than the flush already taken.
- `frontend_flush_o` is registered: it pulses high the cycle after an accepted redirect, together with `frontend_target_o`.
- `stall_cycles_o`: 32-bit, wraps at 2^32-1 to 0. It is not gated by FLUSH.

## Timing
- `stall_vec_o`, `clr_vec_o`: zero latency from the request inputs.
- Redirect: accepted in cycle T → `frontend_flush_o` high in T+1 only. `issue_allow_o` is low from T+1 through T+`FLUSH_CYCLES`, and re-asserts at T+`FLUSH_CYCLES`+1 if not stalled.
- Reset (rst high at a clock edge):
  - state RUN, cnt 0;
  - `frontend_flush_o` 0, `frontend_target_o` 0, `stall_cycles_o` 0.
  - While rst is held, combinational outputs still follow the inputs, but `issue_allow_o` is forced 0.
- Reset mid-FLUSH: the next cycle is RUN with no flush pulse.
- The stall counter increments on the edge that ends any cycle with `stall_vec_o[0]` = 1 and rst low.

## Test plan
- Stall propagation: `m1_stall_req_i`=2'b10, others 0 → `stall_vec_o`=3'b011 and `issue_allow_o`=0. After 5 such cycles, `stall_cycles_o`=5.
- Branch flush: ex_clr=1, `ex_target_i`=0x1C000100, no stall in T → `clr_vec_o[1][0]`=1 in T; `frontend_flush_o`=1 with target 0x1C000100 in T+1; `issue_allow_o`=0 in T+1..T+2 and 1 in T+3.
- Gated clear: ex_clr=1 with `m2_stall_req_i`=2'b01 → not accepted, `clr_vec_o`=0, no flush pulse.
- Syscall: m2_clr=1, exclude_self=1, target 0x1C000008 → `clr_vec_o[0]`=3'b011, `clr_vec_o[1]`=3'b111; flush pulse next cycle with target 0x1C000008.
- Same-cycle conflict: ex_clr (0x100) and m2_clr (0x200) together → target 0x200, a single flush pulse, `clr_vec_o[1][0]`=1.
- M2 clear during FLUSH re-pulses and restarts the window. A second ex_clr during FLUSH gives no pulse. Reset during FLUSH → `issue_allow_o`=1 the first unstalled cycle after rst drops.
